// File: rtl/alu_share_pkg.sv
// Shared types and constants for the shared Hack ALU arbiter.
//  - state_t        : sequencer states (IDLE -> EXEC -> RESP)
//  - CTRL_*         : bit positions inside the 6-bit control word {zx,nx,zy,ny,f,no}
//  - ALU_*          : control words for the common Hack ALU operations
//  - id_width()     : requester-id width, never less than 1 bit
package alu_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    localparam logic [5:0] ALU_ZERO = 6'b101010;
    localparam logic [5:0] ALU_ONE  = 6'b111111;
    localparam logic [5:0] ALU_NEG1 = 6'b111010;
    localparam logic [5:0] ALU_X    = 6'b001100;
    localparam logic [5:0] ALU_Y    = 6'b110000;
    localparam logic [5:0] ALU_ADD  = 6'b000010;
    localparam logic [5:0] ALU_SUB  = 6'b010011;
    localparam logic [5:0] ALU_AND  = 6'b000000;
    localparam logic [5:0] ALU_OR   = 6'b010101;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hack_alu.sv
// Combinational 16-bit Hack ALU.
//  x, y        : operands
//  zx, nx      : zero / invert x before the function
//  zy, ny      : zero / invert y before the function
//  f           : 1 = x+y (carry dropped), 0 = x&y
//  no          : invert the function result
//  out, zr, ng : result, result==0, result[15]
module hack_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z;
    logic [15:0] x_n;
    logic [15:0] y_z;
    logic [15:0] y_n;
    logic [15:0] f_out;

    assign x_z   = zx ? 16'h0000 : x;
    assign x_n   = nx ? ~x_z : x_z;
    assign y_z   = zy ? 16'h0000 : y;
    assign y_n   = ny ? ~y_z : y_z;
    assign f_out = f ? (x_n + y_n) : (x_n & y_n);
    assign out   = no ? ~f_out : f_out;
    assign zr    = (out == 16'h0000);
    assign ng    = out[15];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: returns a one-hot grant for the first asserted request
// at or after position ptr, wrapping around. Grant is zero when no request.
//  req   : request vector
//  ptr   : highest-priority position this cycle (must be < N)
//  grant : one-hot (or zero) grant
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int  idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one Hack ALU between NUM_REQ requesters.
// A round-robin winner's operands and control word are latched in IDLE, the
// ALU result is registered in EXEC, and held on the response channel in RESP
// until the consumer accepts it.
//  clk, rst_n                 : clock, asynchronous active-low reset
//  req_valid/req_ready        : per-requester handshake (ready one-hot or zero)
//  req_x, req_y, req_ctrl     : packed per-requester operands / {zx,nx,zy,ny,f,no}
//  rsp_valid/rsp_ready        : response handshake
//  rsp_out, rsp_zr, rsp_ng    : ALU result and flags
//  rsp_id                     : index of the requester that owns the result
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*16-1:0] req_x,
    input  logic [NUM_REQ*16-1:0] req_y,
    input  logic [NUM_REQ*6-1:0]  req_ctrl,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_out,
    output logic                  rsp_zr,
    output logic                  rsp_ng,
    output logic [ID_W-1:0]       rsp_id
);

    state_t          state_reg;
    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] rr_ptr_next;
    logic [15:0]     x_reg;
    logic [15:0]     y_reg;
    logic [5:0]      ctrl_reg;
    logic [ID_W-1:0] id_reg;
    logic [15:0]     out_reg;
    logic            zr_reg;
    logic            ng_reg;
    logic            rsp_valid_reg;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               accept;

    logic [15:0] x_arr    [NUM_REQ];
    logic [15:0] y_arr    [NUM_REQ];
    logic [5:0]  ctrl_arr [NUM_REQ];

    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign x_arr[gi]    = req_x[16*gi +: 16];
        assign y_arr[gi]    = req_y[16*gi +: 16];
        assign ctrl_arr[gi] = req_ctrl[6*gi +: 6];
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    // Next priority starts just past the winner; with one requester this is always 0.
    assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Ready is offered only while idle; gating with rst_n keeps it low for the
    // whole time reset is asserted, not just after the state has cleared.
    assign req_ready = (state_reg == IDLE && rst_n) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    hack_alu u_alu (
        .x   (x_reg),
        .y   (y_reg),
        .zx  (ctrl_reg[CTRL_ZX]),
        .nx  (ctrl_reg[CTRL_NX]),
        .zy  (ctrl_reg[CTRL_ZY]),
        .ny  (ctrl_reg[CTRL_NY]),
        .f   (ctrl_reg[CTRL_F]),
        .no  (ctrl_reg[CTRL_NO]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            x_reg         <= '0;
            y_reg         <= '0;
            ctrl_reg      <= '0;
            id_reg        <= '0;
            out_reg       <= '0;
            zr_reg        <= 1'b0;
            ng_reg        <= 1'b0;
            rsp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        x_reg      <= x_arr[grant_idx];
                        y_reg      <= y_arr[grant_idx];
                        ctrl_reg   <= ctrl_arr[grant_idx];
                        id_reg     <= grant_idx;
                        rr_ptr_reg <= rr_ptr_next;
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    out_reg       <= alu_out;
                    zr_reg        <= alu_zr;
                    ng_reg        <= alu_ng;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_out   = out_reg;
    assign rsp_zr    = zr_reg;
    assign rsp_ng    = ng_reg;
    assign rsp_id    = id_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with two requesters.
// Expected results are pushed when the reference round-robin model predicts a
// transfer, and popped when the response handshake completes.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*16-1:0] req_x;
    logic [N*16-1:0] req_y;
    logic [N*6-1:0]  req_ctrl;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [15:0]   rsp_out;
    logic          rsp_zr;
    logic          rsp_ng;
    logic [0:0]    rsp_id;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_zr    (rsp_zr),
        .rsp_ng    (rsp_ng),
        .rsp_id    (rsp_id)
    );

    typedef struct packed {
        logic [15:0] out;
        logic        zr;
        logic        ng;
        logic [0:0]  id;
    } rsp_t;

    rsp_t sb[$];
    rsp_t log_q[$];

    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   rem [N];
    int   exp_ptr = 0;
    bit   busy = 1'b0;
    int   accept_cycle = 0;
    bit   prev_valid = 1'b0;
    bit   prev_ready = 1'b1;
    rsp_t prev_rsp;
    int   bp_left = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the arithmetic meaning of each named operation.
    function automatic logic [15:0] ref_op(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            ALU_ZERO: return 16'h0000;
            ALU_ONE:  return 16'h0001;
            ALU_NEG1: return 16'hFFFF;
            ALU_X:    return x;
            ALU_Y:    return y;
            ALU_ADD:  return x + y;
            ALU_SUB:  return x - y;
            ALU_AND:  return x & y;
            ALU_OR:   return x | y;
            default:  return 16'hxxxx;
        endcase
    endfunction

    function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v, input int ptr);
        logic [N-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (g == '0 && v[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction

    task automatic sample();
        logic [N-1:0] eg;
        rsp_t cur;
        rsp_t e;
        bit   was_busy;
        int   g;
        cycle++;
        was_busy = busy;
        cur = '{out: rsp_out, zr: rsp_zr, ng: rsp_ng, id: rsp_id};

        if (!was_busy) chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        if (rsp_valid) begin
            chk("req_ready_in_resp", 32'(req_ready), 32'd0);
            if (!prev_valid) chk("latency", cycle - accept_cycle, 32'd2);
            else if (!prev_ready) chk("rsp_stable", 32'(cur), 32'(prev_rsp));
            if (rsp_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_out", 32'(rsp_out), 32'(e.out));
                    chk("rsp_zr", 32'(rsp_zr), 32'(e.zr));
                    chk("rsp_ng", 32'(rsp_ng), 32'(e.ng));
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                end
                log_q.push_back(cur);
                busy = 1'b0;
                $display("rsp  cyc=%0d id=%0d out=%h zr=%0d ng=%0d", cycle, rsp_id, rsp_out, rsp_zr, rsp_ng);
            end else if (bp_left > 0) begin
                bp_left--;
            end
        end
        prev_valid = rsp_valid;
        prev_ready = rsp_ready;
        prev_rsp   = cur;

        eg = was_busy ? '0 : exp_grant(req_valid, exp_ptr);
        chk("req_ready", 32'(req_ready), 32'(eg));
        if (eg != '0) begin
            g = eg[1] ? 1 : 0;
            e.out = ref_op(req_ctrl[6*g +: 6], req_x[16*g +: 16], req_y[16*g +: 16]);
            e.zr  = (e.out == 16'h0000);
            e.ng  = e.out[15];
            e.id  = 1'(g);
            sb.push_back(e);
            exp_ptr      = (g + 1) % N;
            busy         = 1'b1;
            accept_cycle = cycle;
            rem[g]--;
            $display("acc  cyc=%0d id=%0d x=%h y=%h ctrl=%b", cycle, g,
                     req_x[16*g +: 16], req_y[16*g +: 16], req_ctrl[6*g +: 6]);
        end
    endtask

    task automatic edge_apply();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (rem[i] <= 0) req_valid[i] = 1'b0;
        rsp_ready = (bp_left == 0);
    endtask

    task automatic edge_sample();
        @(negedge clk);
        sample();
    endtask

    task automatic tick();
        edge_apply();
        edge_sample();
    endtask

    task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y,
                           input logic [5:0] c, input int count);
        req_x[16*i +: 16] = x;
        req_y[16*i +: 16] = y;
        req_ctrl[6*i +: 6] = c;
        rem[i]       = count;
        req_valid[i] = (count > 0);
    endtask

    function automatic bit all_done();
        bit d;
        d = !busy;
        for (int i = 0; i < N; i++) if (rem[i] > 0) d = 1'b0;
        return d;
    endfunction

    task automatic run(input string tag, input int budget);
        for (int n = 0; n < budget && !all_done(); n++) tick();
        chk({tag, "_done"}, 32'(all_done()), 32'd1);
        chk({tag, "_sb_drained"}, sb.size(), 32'd0);
    endtask

    task automatic clear_model();
        sb.delete();
        busy       = 1'b0;
        exp_ptr    = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        log_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_x     = '0;
        req_y     = '0;
        req_ctrl  = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) rem[i] = 0;

        // Reset values, with requests pending to prove ready stays low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;
        clear_model();

        // Single op: 0x11 + 0x03.
        edge_apply();
        set_req(0, 16'h0011, 16'h0003, ALU_ADD, 1);
        edge_sample();
        run("single", 20);
        chk("single_n", log_q.size(), 32'd1);
        chk("single_out", 32'(log_q[0].out), 32'h0014);
        chk("single_zr", 32'(log_q[0].zr), 32'd0);
        chk("single_ng", 32'(log_q[0].ng), 32'd0);
        chk("single_id", 32'(log_q[0].id), 32'd0);

        // Collision straight after reset: req0 wins first.
        do_reset();
        edge_apply();
        set_req(0, 16'h1234, 16'h5678, ALU_ZERO, 1);
        set_req(1, 16'h1234, 16'h5678, ALU_NEG1, 1);
        edge_sample();
        run("coll", 40);
        chk("coll_n", log_q.size(), 32'd2);
        chk("coll0_id", 32'(log_q[0].id), 32'd0);
        chk("coll0_out", 32'(log_q[0].out), 32'h0000);
        chk("coll0_zr", 32'(log_q[0].zr), 32'd1);
        chk("coll1_id", 32'(log_q[1].id), 32'd1);
        chk("coll1_out", 32'(log_q[1].out), 32'hFFFF);
        chk("coll1_ng", 32'(log_q[1].ng), 32'd1);

        // Round-robin: both held valid for four ops total.
        log_q.delete();
        edge_apply();
        set_req(0, 16'h1234, 16'h0F0F, ALU_AND, 2);
        set_req(1, 16'h1234, 16'h0F0F, ALU_OR, 2);
        edge_sample();
        run("rr", 60);
        chk("rr_n", log_q.size(), 32'd4);
        for (int k = 0; k < 4; k++) chk("rr_id", 32'(log_q[k].id), 32'(k % 2));

        // Backpressure: five RESP cycles with rsp_ready low, req1 waiting.
        log_q.delete();
        bp_left = 5;
        edge_apply();
        set_req(0, 16'h7FFF, 16'h0001, ALU_ADD, 1);
        set_req(1, 16'h0005, 16'h0005, ALU_SUB, 1);
        edge_sample();
        run("bp", 60);
        chk("bp_consumed", bp_left, 32'd0);
        chk("bp_n", log_q.size(), 32'd2);
        chk("bp0_out", 32'(log_q[0].out), 32'h8000);
        chk("bp0_id", 32'(log_q[0].id), 32'd0);
        chk("bp1_id", 32'(log_q[1].id), 32'd1);
        chk("bp1_zr", 32'(log_q[1].zr), 32'd1);

        // Wrap and sign: 3 - 0x11.
        log_q.delete();
        edge_apply();
        set_req(0, 16'h0003, 16'h0011, ALU_SUB, 1);
        edge_sample();
        run("wrap", 20);
        chk("wrap_n", log_q.size(), 32'd1);
        chk("wrap_out", 32'(log_q[0].out), 32'hFFF2);
        chk("wrap_ng", 32'(log_q[0].ng), 32'd1);
        chk("wrap_zr", 32'(log_q[0].zr), 32'd0);

        // Reset during EXEC after req0 was granted (DUT pointer now at 1).
        log_q.delete();
        edge_apply();
        set_req(0, 16'h0001, 16'h0001, ALU_ADD, 1);
        edge_sample();
        for (int n = 0; n < 20 && !busy; n++) tick();
        chk("mid_accepted", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        set_req(0, 16'h0002, 16'h0002, ALU_ADD, 1);
        set_req(1, 16'h0009, 16'h0001, ALU_SUB, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        edge_sample();
        run("mid", 40);
        chk("mid_n", log_q.size(), 32'd2);
        chk("mid_first_id", 32'(log_q[0].id), 32'd0);
        chk("mid_first_out", 32'(log_q[0].out), 32'h0004);
        chk("mid_second_out", 32'(log_q[1].out), 32'h0008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
